// File: rtl/sine_ram_arb_if.sv
// Request/response bundle between the sine-table requesters and the
// port-0 arbiter: datapath read channel plus host table-load write channel.
interface sine_ram_arb_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ready;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;

    logic              host_wvalid;
    logic [ADDR_W-1:0] host_waddr;
    logic [DATA_W-1:0] host_wdata;
    logic [3:0]        host_wmask;
    logic              host_wready;

    // Requester side: datapath lookup and host loader.
    modport master (
        output rd_req, rd_addr,
        input  rd_ready, rd_valid, rd_data,
        output host_wvalid, host_waddr, host_wdata, host_wmask,
        input  host_wready
    );

    // Arbiter side.
    modport slave (
        input  rd_req, rd_addr,
        output rd_ready, rd_valid, rd_data,
        input  host_wvalid, host_waddr, host_wdata, host_wmask,
        output host_wready
    );
endinterface

// File: rtl/sine_ram_arb.sv
// Port-0 controller for the 256x32 sine-table SRAM. Arbitrates between the
// phase-counter read path and the host table loader, tracks load progress,
// masks reads until the table is complete and drives the active-low
// csb0/web0 SRAM controls from registers.
module sine_ram_arb #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32,
    parameter int RD_LAT     = 1,
    parameter int STARVE_LIM = 8
) (
    input  logic              clk,
    input  logic              reset,
    sine_ram_arb_if.slave     bus,
    input  logic              tbl_clear,
    output logic              table_ready,
    output logic [ADDR_W:0]   load_count,
    output logic              csb0,
    output logic              web0,
    output logic [3:0]        wmask0,
    output logic [ADDR_W-1:0] addr0,
    output logic [DATA_W-1:0] din0,
    input  logic [DATA_W-1:0] dout0
);
    localparam int                DEPTH      = 1 << ADDR_W;
    localparam logic [ADDR_W:0]   FULL_CNT   = DEPTH[ADDR_W:0];
    localparam int                SC_W       = $clog2(STARVE_LIM + 1);
    localparam logic [SC_W-1:0]   STARVE_MAX = STARVE_LIM[SC_W-1:0];

    logic [SC_W-1:0] starve_cnt;
    logic            force_wr;
    logic            wr_acc;
    logic            rd_acc;

    // Stage N of the read return pipe: a read is in flight, and whether it
    // touched the SRAM (table loaded at accept time) or must return zero.
    logic [RD_LAT:0] vld_p;
    logic [RD_LAT:0] live_p;

    // A write that has waited long enough overrides the read priority.
    assign force_wr        = (starve_cnt == STARVE_MAX);
    assign bus.host_wready = !bus.rd_req | force_wr;
    assign bus.rd_ready    = !(force_wr & bus.host_wvalid);

    // The grant equations make these mutually exclusive.
    assign wr_acc = bus.host_wvalid & bus.host_wready;
    assign rd_acc = bus.rd_req & bus.rd_ready;

    // Count consecutive blocked cycles of a pending write, saturating.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else if (bus.host_wvalid && !wr_acc) begin
            if (starve_cnt != STARVE_MAX)
                starve_cnt <= starve_cnt + 1'b1;
        end else begin
            starve_cnt <= '0;
        end
    end

    // Load progress: count accepted writes up to DEPTH; a clear restarts
    // the count but still counts a write accepted on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            load_count  <= '0;
            table_ready <= 1'b0;
        end else if (tbl_clear) begin
            load_count  <= wr_acc ? {{ADDR_W{1'b0}}, 1'b1} : '0;
            table_ready <= 1'b0;
        end else if (wr_acc && load_count != FULL_CNT) begin
            load_count <= load_count + 1'b1;
            if (load_count == FULL_CNT - 1'b1)
                table_ready <= 1'b1;
        end
    end

    // Registered SRAM port: one access per cycle, address/data hold when idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            csb0   <= 1'b1;
            web0   <= 1'b1;
            wmask0 <= '0;
            addr0  <= '0;
            din0   <= '0;
        end else if (wr_acc) begin
            csb0   <= 1'b0;
            web0   <= 1'b0;
            wmask0 <= bus.host_wmask;
            addr0  <= bus.host_waddr;
            din0   <= bus.host_wdata;
        end else if (rd_acc && table_ready) begin
            csb0   <= 1'b0;
            web0   <= 1'b1;
            wmask0 <= '0;
            addr0  <= bus.rd_addr;
        end else begin
            csb0   <= 1'b1;
            web0   <= 1'b1;
            wmask0 <= '0;
        end
    end

    // Read return pipe: stage 0 loads on the accept edge, stage RD_LAT
    // lines up with dout0 being valid on the following edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p  <= '0;
            live_p <= '0;
        end else begin
            // stage 0: accept edge
            // stages 1..RD_LAT: SRAM access and read latency
            vld_p  <= {vld_p[RD_LAT-1:0], rd_acc};
            live_p <= {live_p[RD_LAT-1:0], rd_acc & table_ready};
        end
    end

    // Capture: return the SRAM word, or zero for reads masked at accept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.rd_valid <= 1'b0;
            bus.rd_data  <= '0;
        end else begin
            bus.rd_valid <= vld_p[RD_LAT];
            if (vld_p[RD_LAT])
                bus.rd_data <= live_p[RD_LAT] ? dout0 : '0;
        end
    end
endmodule

// File: tb/tb_sine_ram_arb.sv
// Bench for sine_ram_arb: behavioural SRAM, reference table model and a
// scoreboard of expected read returns (data and arrival cycle).
module tb_sine_ram_arb;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 256;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              tbl_clear = 1'b0;
    logic              table_ready;
    logic [ADDR_W:0]   load_count;
    logic              csb0, web0;
    logic [3:0]        wmask0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] din0;
    logic [DATA_W-1:0] dout0 = '0;

    sine_ram_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

    sine_ram_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(1), .STARVE_LIM(8)) dut (
        .clk(clk), .reset(reset), .bus(bus), .tbl_clear(tbl_clear),
        .table_ready(table_ready), .load_count(load_count),
        .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0),
        .din0(din0), .dout0(dout0)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] data;
        int                cyc;
    } exp_t;

    exp_t              sb[$];
    logic [DATA_W-1:0] sram    [DEPTH];
    logic [DATA_W-1:0] ref_mem [DEPTH];
    int                m_count = 0;
    logic              m_ready = 1'b0;
    int                cyc = 0;
    int                wr_cyc = 0;
    int                wr_stalls = 0;
    int                n_chk = 0;
    int                n_fail = 0;
    exp_t              e;
    logic              wr_now;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            sram[i]    = '0;
            ref_mem[i] = '0;
        end
    end

    // Behavioural SRAM: one-cycle read latency, byte-masked writes.
    always @(posedge clk) begin
        if (csb0 === 1'b0) begin
            if (web0 === 1'b0) begin
                for (int b = 0; b < 4; b++)
                    if (wmask0[b]) sram[addr0][8*b +: 8] <= din0[8*b +: 8];
            end else begin
                dout0 <= sram[addr0];
            end
        end
    end

    // Edge counter used to time read returns.
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare returns, predict acceptances on the coming edge.
    always @(negedge clk) begin
        if (!reset) begin
            sb.delete();
            m_count = 0;
            m_ready = 1'b0;
        end else begin
            check("load_count", load_count, m_count);
            check("table_ready", table_ready, m_ready);
            if (bus.rd_valid) begin
                if (sb.size() == 0) begin
                    check("rdv_unexp", bus.rd_valid, 0);
                end else begin
                    e = sb.pop_front();
                    check("rd_data", bus.rd_data, e.data);
                    check("rd_lat", cyc, e.cyc);
                end
            end
            if (!csb0 && !web0) wr_cyc++;
            if (bus.rd_req && bus.rd_ready) begin
                e.data = m_ready ? ref_mem[bus.rd_addr] : '0;
                e.cyc  = cyc + 3;
                sb.push_back(e);
            end
            wr_now = bus.host_wvalid && bus.host_wready;
            if (wr_now)
                for (int b = 0; b < 4; b++)
                    if (bus.host_wmask[b]) ref_mem[bus.host_waddr][8*b +: 8] = bus.host_wdata[8*b +: 8];
            if (tbl_clear) begin
                m_count = wr_now ? 1 : 0;
                m_ready = 1'b0;
            end else if (wr_now && m_count != DEPTH) begin
                m_count++;
                if (m_count == DEPTH) m_ready = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_one(input logic [7:0] a, input logic [31:0] d, input logic [3:0] m);
        int n = 0;
        bus.host_wvalid = 1'b1;
        bus.host_waddr  = a;
        bus.host_wdata  = d;
        bus.host_wmask  = m;
        @(negedge clk);
        while (!bus.host_wready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (n >= 50) check("wr_accept", bus.host_wready, 1);
        wr_stalls += n;
        tick();
        bus.host_wvalid = 1'b0;
    endtask

    task automatic rd_one(input logic [7:0] a);
        bus.rd_req  = 1'b1;
        bus.rd_addr = a;
        @(negedge clk);
        check("rd_ready", bus.rd_ready, 1);
        tick();
        bus.rd_req = 1'b0;
    endtask

    task automatic check_reset_vals();
        check("rst_csb0", csb0, 1);
        check("rst_web0", web0, 1);
        check("rst_wmask0", wmask0, 0);
        check("rst_addr0", addr0, 0);
        check("rst_din0", din0, 0);
        check("rst_rd_valid", bus.rd_valid, 0);
        check("rst_rd_data", bus.rd_data, 0);
        check("rst_table_ready", table_ready, 0);
        check("rst_load_count", load_count, 0);
    endtask

    initial begin
        int snap;
        int blocked;
        bus.rd_req = 1'b0; bus.rd_addr = '0;
        bus.host_wvalid = 1'b0; bus.host_waddr = '0; bus.host_wdata = '0; bus.host_wmask = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals();
        check("rst_wready", bus.host_wready, 1);
        check("rst_rd_ready", bus.rd_ready, 1);
        tick();
        reset = 1'b1;

        // Reset mid-load with two reads in flight.
        for (int i = 0; i < 100; i++) wr_one(8'(i), 32'(i * 3), 4'hF);
        bus.rd_req = 1'b1; bus.rd_addr = 8'd1;
        tick();
        bus.rd_addr = 8'd2;
        tick();
        bus.rd_req = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check_reset_vals();
        repeat (2) tick();
        reset = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("no_rdv_after_rst", bus.rd_valid, 0);
        end
        tick();

        // Masked read before the table is loaded.
        bus.rd_req = 1'b1; bus.rd_addr = 8'd5;
        @(negedge clk);
        check("masked_rdy", bus.rd_ready, 1);
        tick();
        bus.rd_req = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("masked_csb0", csb0, 1);
        end
        tick();

        // Full load: 256 sequential writes, data i*3.
        snap = wr_cyc;
        wr_stalls = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i == DEPTH - 1) begin
                check("pre_full_cnt", load_count, DEPTH - 1);
                check("pre_full_rdy", table_ready, 0);
            end
            wr_one(8'(i), 32'(i * 3), 4'hF);
        end
        check("full_cnt", load_count, DEPTH);
        check("full_rdy", table_ready, 1);
        check("full_stalls", wr_stalls, 0);
        repeat (3) tick();
        check("full_wr_cycles", wr_cyc - snap, DEPTH);

        // Pipelined reads of addresses 0..9.
        for (int i = 0; i < 10; i++) begin
            bus.rd_req = 1'b1; bus.rd_addr = 8'(i);
            @(negedge clk);
            check("pipe_rdy", bus.rd_ready, 1);
            tick();
        end
        bus.rd_req = 1'b0;
        repeat (5) tick();

        // Starvation: continuous reads block a write for exactly 8 cycles.
        bus.rd_req = 1'b1; bus.rd_addr = 8'd0;
        bus.host_wvalid = 1'b1; bus.host_waddr = 8'd7;
        bus.host_wdata = 32'hDEADBEEF; bus.host_wmask = 4'hF;
        blocked = 0;
        @(negedge clk);
        while (!bus.host_wready && blocked < 20) begin
            check("starve_rd_ready_hi", bus.rd_ready, 1);
            blocked++;
            @(negedge clk);
        end
        check("starve_blocked", blocked, 8);
        check("starve_rd_ready_lo", bus.rd_ready, 0);
        tick();
        bus.host_wvalid = 1'b0;
        @(negedge clk);
        check("starve_rd_ready_back", bus.rd_ready, 1);
        tick();
        bus.rd_addr = 8'd7;
        tick();
        bus.rd_req = 1'b0;
        repeat (5) tick();

        // Partial-mask patch after load; table stays ready.
        wr_one(8'd9, 32'hAABBCCDD, 4'b0101);
        check("patch_rdy", table_ready, 1);
        tick();
        rd_one(8'd9);
        repeat (5) tick();

        // Clear on the same edge as an accepted write.
        tbl_clear = 1'b1;
        bus.host_wvalid = 1'b1; bus.host_waddr = 8'd3;
        bus.host_wdata = 32'h12345678; bus.host_wmask = 4'hF;
        @(negedge clk);
        check("clr_wready", bus.host_wready, 1);
        tick();
        tbl_clear = 1'b0;
        bus.host_wvalid = 1'b0;
        check("clr_rdy", table_ready, 0);
        check("clr_cnt", load_count, 1);
        rd_one(8'd3);
        repeat (5) tick();
        check("sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sine_ram_arb.md
Name: sine_ram_arb

Overview:
Controller and arbiter for the single read/write port (port 0) of the 256x32 sine-table SRAM used by the counter datapath. It shares the port between the phase-counter lookup path (read requester) and a host table loader (write requester). It tracks whether the table is fully loaded, masks reads until it is, and drives the OpenRAM-style active-low csb0/web0 controls.

Parameters:
ADDR_W, 8, table address width; DEPTH = 2**ADDR_W entries
DATA_W, 32, table word width
RD_LAT, 1, SRAM read latency in cycles from the access edge to dout0 valid (1..3)
STARVE_LIM, 8, consecutive blocked cycles of a pending write before it wins over a read

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  asynchronous active-low reset (low = reset asserted)
rd_req  in  1  datapath read request
rd_addr  in  ADDR_W  table index (counter cout)
rd_ready  out  1  read accepted when rd_req & rd_ready at rising edge
rd_valid  out  1  one-cycle pulse, rd_data valid
rd_data  out  DATA_W  returned table word (sine_out source)
host_wvalid  in  1  host write request
host_waddr  in  ADDR_W  write address
host_wdata  in  DATA_W  write data
host_wmask  in  4  byte write mask
host_wready  out  1  write accepted when host_wvalid & host_wready at rising edge
tbl_clear  in  1  synchronous: invalidate table and clear load count
table_ready  out  1  DEPTH writes accepted since reset or clear
load_count  out  ADDR_W+1  accepted-write count, saturates at DEPTH
csb0  out  1  SRAM chip select, active low
web0  out  1  SRAM write enable, active low
wmask0  out  4  SRAM byte mask
addr0  out  ADDR_W  SRAM address
din0  out  DATA_W  SRAM write data
dout0  in  DATA_W  SRAM read data

Behaviour:
- Reset (reset low, async): csb0=1, web0=1, wmask0=0, addr0=0, din0=0, rd_valid=0, rd_data=0, table_ready=0, load_count=0, starve counter=0. In-flight reads are discarded; no rd_valid for them after reset release.
- At most one SRAM access per cycle. Grant logic is combinational from the current inputs:
  force_wr = (starve_cnt == STARVE_LIM)
  host_wready = !rd_req | force_wr
  rd_ready = !(force_wr & host_wvalid)
- Default priority is read over write, so the datapath does not stall.
- starve_cnt increments, saturating at STARVE_LIM, in each cycle where host_wvalid=1 and the write is not accepted. It clears on an accepted write or when host_wvalid=0.
- Accepted write at edge T: the registered SRAM outputs carry the access in cycle T..T+1: csb0=0, web0=0, addr0=host_waddr, din0=host_wdata, wmask0=host_wmask. load_count increments, saturating at DEPTH.
- Accepted read at edge T with table_ready=1:
  - csb0=0, web0=1, wmask0=0, addr0=rd_addr in cycle T..T+1.
  - dout0 is captured into rd_data at edge T+1+RD_LAT, and rd_valid=1 in that cycle only.
  - Back-to-back reads are fully pipelined at one per cycle. The return order equals the request order.
- Accepted read with table_ready=0: no SRAM access (csb0 stays 1). rd_valid pulses with the same latency, with rd_data=0.
- Cycles with no grant: csb0=1, web0=1, wmask0=0. addr0 and din0 hold their last values.
- table_ready rises at the edge where load_count becomes DEPTH. Reads accepted at that same edge are still masked.
- Writes after table_ready are allowed (table patching). They do not change table_ready.
- tbl_clear: load_count=0 and table_ready=0 at the next edge. A write accepted at the same edge counts, giving load_count=1. Reads already in flight complete normally.
- Simultaneous rd_req and host_wvalid with force_wr=0: the read is granted and the write waits.
- Simultaneous rd_req and host_wvalid with force_wr=1: the write is granted, rd_ready=0, and the read retries the next cycle.

Test Plan:
- Reset mid-load: reset low after 100 writes with 2 reads in flight -> all outputs at reset values, load_count=0, no rd_valid pulses after release.
- Full load: 256 sequential writes, data i*3, rd_req=0 -> host_wready=1 throughout, load_count=256, table_ready rises on the 256th accept edge, csb0/web0 low for 256 cycles.
- Masked read: rd_req with addr 5 before the load completes -> rd_valid 2 cycles after accept (RD_LAT=1), rd_data=0, csb0 never low.
- Pipelined reads: after load, reads of addr 0..9 on consecutive cycles -> rd_valid high 10 consecutive cycles starting accept+2, rd_data=0,3,...,27.
- Starvation: continuous rd_req plus host_wvalid at addr 7, data 0xDEADBEEF -> write accepted after exactly 8 blocked cycles, rd_ready=0 that cycle only, later read of addr 7 returns 0xDEADBEEF.
- Clear during write: tbl_clear and an accepted write on the same edge with table_ready=1 -> table_ready=0, load_count=1.
